mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, width of address buses.
REQ-002 Parameter DW, default 16, width of data buses.
REQ-003 Parameter MAX_BURST, default 16, maximum DMA transfers per grant (1..255).
REQ-004 Parameter COOLDOWN, default 2, minimum cycles the CPU owns the bus between grants (>=1).
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 cpu_addr  input  AW  CPU address.
REQ-008 cpu_dout  input  DW  CPU write data.
REQ-009 cpu_we  input  1  CPU write enable.
REQ-010 cpu_busy  input  1  CPU acknowledge: 1 = CPU stalled by hold.
REQ-011 cpu_hold  output  1  stall request to CPU.
REQ-012 dma_req  input  1  DMA requests bus; 1 in grant = one transfer this cycle.
REQ-013 dma_addr  input  AW  DMA address.
REQ-014 dma_wdata  input  DW  DMA write data.
REQ-015 dma_we  input  1  DMA write enable.
REQ-016 dma_gnt  output  1  DMA owns bus.
REQ-017 dma_rvalid  output  1  read data on memory dout valid for DMA this cycle.
REQ-018 mem_addr  output  AW  shared memory address.
REQ-019 mem_wdata  output  DW  shared memory write data.
REQ-020 mem_we  output  1  shared memory write enable.

Function
REQ-021 FSM states: IDLE, HOLDING, GRANT, RELEASE; cpu_hold=1 in HOLDING and GRANT only; dma_gnt=1 in GRANT only (both registered).
REQ-022 IDLE: dma_req=1 and cooldown counter expired -> HOLDING next cycle; else stay.
REQ-023 HOLDING: cpu_busy=1 and dma_req=1 -> GRANT; dma_req=0 -> IDLE (request withdrawn, no grant); else stay, no timeout.
REQ-024 GRANT: each cycle with dma_req=1 is one transfer and increments 8-bit burst counter (cleared on entry to GRANT).
REQ-025 GRANT -> RELEASE when dma_req=0, or when the transfer that makes counter equal MAX_BURST occurs (that transfer completes).
REQ-026 RELEASE: hold and gnt deasserted, cooldown counter loaded with COOLDOWN-1, -> IDLE next cycle; counter decrements each IDLE cycle, saturating at 0.
REQ-027 Bus mux combinational: dma_gnt=1 -> mem_addr=dma_addr, mem_wdata=dma_wdata, mem_we=dma_we&dma_req; else CPU signals, mem_we=cpu_we&~cpu_hold.
REQ-028 CPU writes suppressed whenever cpu_hold=1 (HOLDING included) so a stalling CPU cannot corrupt memory.
REQ-029 dma_rvalid registered: 1 exactly one cycle after a GRANT cycle with dma_req=1 and dma_we=0 (matches one-cycle synchronous RAM latency), including the cycle after the final burst transfer.
REQ-030 cpu_busy falling during GRANT is ignored; grant holds until REQ-025 exit.
REQ-031 DMA burst length beyond MAX_BURST requires a new request cycle after cooldown; re-entry path RELEASE->IDLE->HOLDING is mandatory.

Reset
REQ-032 reset_n=0 immediately forces IDLE, cpu_hold=0, dma_gnt=0, dma_rvalid=0, burst and cooldown counters 0, mem mux to CPU.
REQ-033 Reset asserted mid-burst aborts the grant with no further DMA writes; first post-reset cycle behaves as IDLE.

Verification
REQ-034 Idle: dma_req=0, CPU writes 0x1234 to 0x0010 -> mem_we=1, mem_addr=0x0010, cpu_hold=0 throughout.
REQ-035 Handshake: dma_req=1, cpu_busy rises 3 cycles later -> cpu_hold=1 cycle+1, dma_gnt=1 the cycle after cpu_busy seen, CPU write attempts during HOLDING give mem_we=0.
REQ-036 Burst cap: MAX_BURST=4, dma_req held high, reads 0x0100..0x0103 -> exactly 4 transfers, 4 dma_rvalid pulses each one cycle late, gnt drops, next gnt no earlier than COOLDOWN+2 cycles later.
REQ-037 Withdrawal: dma_req pulsed 1 cycle with cpu_busy=0 -> HOLDING then IDLE, dma_gnt never 1, cpu_hold=1 for one cycle only.
REQ-038 Reset mid-burst: reset_n=0 during 2nd DMA write -> dma_gnt, cpu_hold, mem_we from DMA go 0 asynchronously; counters 0 after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one synchronous RAM port between a CPU and a DMA engine.
//   The DMA asks for the bus with dma_req. The arbiter raises cpu_hold and
//   waits for the CPU to acknowledge the stall on cpu_busy. It then grants
//   the DMA up to MAX_BURST transfers. Afterwards the bus returns to the CPU
//   for at least COOLDOWN cycles before the DMA can be granted again.
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   cpu_addr   : CPU address                     [AW]
//   cpu_dout   : CPU write data                  [DW]
//   cpu_we     : CPU write enable
//   cpu_busy   : CPU acknowledges the stall
//   cpu_hold   : stall request to CPU (registered)
//   dma_req    : DMA request / one transfer per grant cycle
//   dma_addr   : DMA address                     [AW]
//   dma_wdata  : DMA write data                  [DW]
//   dma_we     : DMA write enable
//   dma_gnt    : DMA owns the bus (registered)
//   dma_rvalid : RAM read data valid for the DMA this cycle (registered)
//   mem_addr   : shared memory address           [AW]
//   mem_wdata  : shared memory write data        [DW]
//   mem_we     : shared memory write enable
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16,
  parameter int COOLDOWN  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_we,
  input  logic          cpu_busy,
  output logic          cpu_hold,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_we,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we
);

  // The cooldown counter only ever holds COOLDOWN-1 or less.
  localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDING = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      burst_cnt, burst_nxt;
  logic [CD_W-1:0] cd_cnt, cd_nxt;
  logic            hold_nxt, gnt_nxt, rvalid_nxt;
  logic            xfer, last_xfer;

  // One transfer happens in every grant cycle that has the request asserted.
  // The transfer that brings the count up to MAX_BURST still completes, and
  // the grant ends after it.
  assign xfer      = (state == GRANT) && dma_req;
  assign last_xfer = xfer && (burst_cnt == 8'(MAX_BURST - 1));

  // ---- next-state / counter logic ----
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    cd_nxt    = cd_cnt;
    case (state)
      IDLE: begin
        if (dma_req && (cd_cnt == '0)) begin
          state_nxt = HOLDING;
        end
        if (cd_cnt != '0) begin
          cd_nxt = cd_cnt - CD_W'(1);
        end
      end
      HOLDING: begin
        // There is no timeout here. The DMA either withdraws its request or
        // the CPU eventually acknowledges the stall.
        if (!dma_req) begin
          state_nxt = IDLE;
        end else if (cpu_busy) begin
          state_nxt = GRANT;
          burst_nxt = 8'd0;
        end
      end
      GRANT: begin
        // cpu_busy is deliberately ignored once the bus is granted.
        if (xfer) begin
          burst_nxt = burst_cnt + 8'd1;
        end
        if (!dma_req || last_xfer) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        cd_nxt    = CD_W'(COOLDOWN - 1);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state, so they line up
  // with the state register.
  always_comb begin
    hold_nxt   = (state_nxt == HOLDING) || (state_nxt == GRANT);
    gnt_nxt    = (state_nxt == GRANT);
    // The RAM has one cycle of read latency, so read data becomes valid in
    // the cycle after a DMA read transfer.
    rvalid_nxt = xfer && !dma_we;
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      burst_cnt  <= 8'd0;
      cd_cnt     <= '0;
      cpu_hold   <= 1'b0;
      dma_gnt    <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      cd_cnt     <= cd_nxt;
      cpu_hold   <= hold_nxt;
      dma_gnt    <= gnt_nxt;
      dma_rvalid <= rvalid_nxt;
    end
  end

  // ---- bus mux ----
  // Reset clears dma_gnt and cpu_hold asynchronously, so the bus falls back
  // to the CPU immediately. A held CPU can never write, even while it has
  // not yet acknowledged the stall.
  always_comb begin
    if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we & dma_req;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      mem_we    = cpu_we & ~cpu_hold;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int MAX_BURST = 4;
  localparam int COOLDOWN  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic          cpu_we;
  logic          cpu_busy;
  logic          cpu_hold;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_we;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;

  mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_busy(cpu_busy), .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_we(dma_we), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the bus, how many transfers are done, and
  // how many idle cycles must still pass before a new request is honoured.
  bit m_hold, m_gnt, m_rel, m_rv;
  int m_burst, m_wait;

  // Samples of the DUT outputs taken in the middle of the latest cycle.
  logic          s_hold, s_gnt, s_rv, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_gnt = 0; m_rel = 0; m_rv = 0; m_burst = 0; m_wait = 0;
  endtask

  task automatic model_clock();
    bit n_hold, n_gnt, n_rel;
    int n_burst, n_wait;
    n_hold  = m_hold;
    n_gnt   = m_gnt;
    n_rel   = 0;
    n_burst = m_burst;
    n_wait  = m_wait;
    m_rv    = m_gnt && dma_req && !dma_we;
    if (m_rel) begin
      n_wait = COOLDOWN - 1;
    end else if (m_gnt) begin
      if (dma_req) n_burst++;
      if (!dma_req || n_burst == MAX_BURST) begin
        n_gnt = 0; n_hold = 0; n_rel = 1;
      end
    end else if (m_hold) begin
      if (!dma_req) n_hold = 0;
      else if (cpu_busy) begin
        n_gnt = 1; n_burst = 0;
      end
    end else begin
      if (dma_req && m_wait == 0) n_hold = 1;
      if (m_wait > 0) n_wait--;
    end
    m_hold = n_hold; m_gnt = n_gnt; m_rel = n_rel;
    m_burst = n_burst; m_wait = n_wait;
  endtask

  // Check one cycle at the falling edge, then advance the model on the
  // rising edge. Inputs are changed 1 time unit after the rising edge.
  task automatic step();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_we;
    @(negedge clk);
    s_hold = cpu_hold; s_gnt = dma_gnt; s_rv = dma_rvalid;
    s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we;
    if (m_gnt) begin
      e_addr = dma_addr; e_wdata = dma_wdata; e_we = dma_we & dma_req;
    end else begin
      e_addr = cpu_addr; e_wdata = cpu_dout; e_we = cpu_we & ~m_hold;
    end
    chk("cpu_hold",   32'(s_hold),  32'(m_hold));
    chk("dma_gnt",    32'(s_gnt),   32'(m_gnt));
    chk("dma_rvalid", 32'(s_rv),    32'(m_rv));
    chk("mem_addr",   32'(s_addr),  32'(e_addr));
    chk("mem_wdata",  32'(s_wdata), 32'(e_wdata));
    chk("mem_we",     32'(s_we),    32'(e_we));
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    dma_req = 0; cpu_busy = 0; cpu_we = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int xfers, rvs, first_drop, next_rise, holds, gnts;
    bit prev_gnt;
    reset_n = 0;
    cpu_addr = '0; cpu_dout = '0; cpu_we = 0; cpu_busy = 0;
    dma_req = 0; dma_addr = '0; dma_wdata = '0; dma_we = 0;
    model_reset();

    // Reset state
    step();
    chk("rst_hold",   32'(s_hold), 32'd0);
    chk("rst_gnt",    32'(s_gnt),  32'd0);
    chk("rst_rvalid", 32'(s_rv),   32'd0);
    step();
    reset_n = 1;
    idle_cycles(2);

    // Idle CPU write
    cpu_we = 1; cpu_addr = 16'h0010; cpu_dout = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_we",    32'(s_we),    32'd1);
      chk("idle_addr",  32'(s_addr),  32'h0010);
      chk("idle_wdata", 32'(s_wdata), 32'h1234);
      chk("idle_hold",  32'(s_hold),  32'd0);
    end

    // Handshake: cpu_busy rises 3 cycles after the request
    dma_req = 1; dma_we = 0; dma_addr = 16'h0300; cpu_we = 1; cpu_addr = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      cpu_busy = (i >= 3);
      step();
      if (i == 0) chk("hs_hold_c0", 32'(s_hold), 32'd0);
      if (i == 1) begin
        chk("hs_hold_c1", 32'(s_hold), 32'd1);
        chk("hs_cpu_we_blocked", 32'(s_we), 32'd0);
      end
      if (i == 3) chk("hs_gnt_c3", 32'(s_gnt), 32'd0);
      if (i == 4) chk("hs_gnt_c4", 32'(s_gnt), 32'd1);
    end
    idle_cycles(5);

    // Burst cap: request held high, reads from 0x0100 upwards
    dma_req = 1; dma_we = 0; cpu_busy = 1; cpu_we = 0;
    xfers = 0; rvs = 0; first_drop = -1; next_rise = -1; prev_gnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      dma_addr = 16'h0100 + 16'(xfers);
      step();
      if (s_gnt && first_drop < 0) begin
        xfers++;
        chk("burst_addr", 32'(s_addr), 32'(16'h0100 + 16'(xfers - 1)));
      end
      if (s_rv && (first_drop < 0 || cyc == first_drop)) rvs++;
      if (!s_gnt && prev_gnt && first_drop < 0) first_drop = cyc;
      if (s_gnt && !prev_gnt && first_drop >= 0 && next_rise < 0) next_rise = cyc;
      prev_gnt = s_gnt;
    end
    chk("burst_xfers",  32'(xfers), 32'(MAX_BURST));
    chk("burst_rvalid", 32'(rvs),   32'(MAX_BURST));
    chk("burst_regrant_gap", 32'(next_rise - first_drop), 32'(COOLDOWN + 2));
    idle_cycles(6);

    // Withdrawal: one-cycle request with no acknowledge
    holds = 0; gnts = 0;
    dma_req = 1; cpu_busy = 0;
    step();
    holds += int'(s_hold); gnts += int'(s_gnt);
    dma_req = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      holds += int'(s_hold); gnts += int'(s_gnt);
    end
    chk("wd_hold_cycles", 32'(holds), 32'd1);
    chk("wd_gnt_cycles",  32'(gnts),  32'd0);
    idle_cycles(3);

    // Reset in the middle of a DMA write burst
    dma_req = 1; dma_we = 1; cpu_busy = 1; cpu_we = 0;
    dma_addr = 16'h0200; dma_wdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) step();
    chk("mid_gnt_before_rst", 32'(dma_gnt), 32'd1);
    chk("mid_we_before_rst",  32'(mem_we),  32'd1);
    #2;
    reset_n = 0;
    #1;
    chk("async_rst_gnt",  32'(dma_gnt),    32'd0);
    chk("async_rst_hold", 32'(cpu_hold),   32'd0);
    chk("async_rst_we",   32'(mem_we),     32'd0);
    chk("async_rst_rv",   32'(dma_rvalid), 32'd0);
    model_reset();
    step();
    step();
    reset_n = 1;
    step();
    step();
    // Cooldown counter cleared by reset: the request is honoured at once.
    chk("post_rst_hold", 32'(s_hold), 32'd1);
    idle_cycles(6);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      dma_req   = ($urandom_range(0, 3) != 0);
      cpu_busy  = $urandom_range(0, 1);
      dma_we    = $urandom_range(0, 1);
      cpu_we    = $urandom_range(0, 1);
      dma_addr  = AW'($urandom);
      dma_wdata = DW'($urandom);
      cpu_addr  = AW'($urandom);
      cpu_dout  = DW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
